// File: rtl/vga_cap_pkg.sv
// vga_cap_pkg: shared types and constants for the VGA stream capture block.
//   PIX_W        : packed {R,G,B} pixel width
//   DEF_H/V_*    : default active frame geometry
//   cap_state_e  : capture FSM states
//   cap_word_t   : buffer entry, pixel plus packet framing bits
package vga_cap_pkg;
  localparam int PIX_W        = 24;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    WAIT_VS     = 2'd0,
    WAIT_ACTIVE = 2'd1,
    ACTIVE      = 2'd2,
    DROP        = 2'd3
  } cap_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sop;
    logic             eop;
  } cap_word_t;
endpackage

// File: rtl/vga_cap_fifo.sv
// vga_cap_fifo: synchronous show-ahead FIFO of cap_word_t entries.
//   clk, reset_n : clock, async active-low reset (empties the FIFO)
//   i_wr_en      : push request, honoured when not full or when reading
//   i_wr_data    : entry to push
//   i_rd_en      : pop request, honoured when not empty
//   o_rd_data    : head entry, all-zero while empty
//   o_full/empty : occupancy flags
module vga_cap_fifo
  import vga_cap_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_wr_en,
  input  cap_word_t i_wr_data,
  input  logic      i_rd_en,
  output cap_word_t o_rd_data,
  output logic      o_full,
  output logic      o_empty
);
  localparam int AW = $clog2(DEPTH);

  cap_word_t   r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic        w_wr, w_rd;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_rd    = i_rd_en & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign w_wr    = i_wr_en & (~o_full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/vga_stream_capture.sv
// vga_stream_capture: captures active VGA pixels into an Avalon-ST stream.
//   clk, reset_n           : clock, async active-low reset
//   vga_HS/VS              : active-low syncs
//   vga_BLANK              : 1 = active pixel
//   vga_R/G/B              : pixel colour, valid when pix_en
//   pix_en                 : pixel strobe
//   stream_*               : Avalon-ST source, readyLatency 0, data = {R,G,B}
//   overflow, frame_err    : sticky status, cleared by status_clr
//   frame_count            : completed frames delivered (only with VGA_CAP_FRAME_COUNT_EN)
// Optional feature macro: VGA_CAP_FRAME_COUNT_EN
module vga_stream_capture
  import vga_cap_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             vga_HS,
  input  logic             vga_VS,
  input  logic             vga_BLANK,
  input  logic [7:0]       vga_R,
  input  logic [7:0]       vga_G,
  input  logic [7:0]       vga_B,
  input  logic             pix_en,
  output logic [PIX_W-1:0] stream_data,
  output logic             stream_startofpacket,
  output logic             stream_endofpacket,
  output logic             stream_valid,
  input  logic             stream_ready,
  output logic             overflow,
  output logic             frame_err,
`ifdef VGA_CAP_FRAME_COUNT_EN
  input  logic             status_clr,
  output logic [15:0]      frame_count
`else
  input  logic             status_clr
`endif
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  // One registered sample stage; *_d hold the previous sample for edge detection.
  logic             r_pv, r_hs, r_hs_d, r_vs, r_vs_d, r_blank;
  logic [PIX_W-1:0] r_rgb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pv    <= 1'b0;
      r_hs    <= 1'b0;
      r_hs_d  <= 1'b0;
      // Syncs reset low so a sync held low through reset is not taken as an edge.
      r_vs    <= 1'b0;
      r_vs_d  <= 1'b0;
      r_blank <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_pv <= pix_en;
      if (pix_en) begin
        r_hs    <= vga_HS;
        r_hs_d  <= r_hs;
        r_vs    <= vga_VS;
        r_vs_d  <= r_vs;
        r_blank <= vga_BLANK;
        r_rgb   <= {vga_R, vga_G, vga_B};
      end
    end
  end

  cap_state_e    r_state;
  logic [XW-1:0] r_x, w_px;
  logic [YW-1:0] r_y, w_py;
  logic          r_realign, r_ovf, r_ferr;
  logic          w_vs_fall, w_hs_fall, w_hs_err, w_realign;
  logic          w_take, w_push, w_ovf_set, w_ferr_set, w_rd;
  logic          w_sop, w_eop, w_full, w_empty;
  cap_word_t     w_wr_word, w_rd_word;

  assign w_vs_fall = r_pv & r_vs_d & ~r_vs;
  assign w_hs_fall = r_pv & r_hs_d & ~r_hs;
  assign w_hs_err  = (r_state == ACTIVE) & w_hs_fall & (r_x != '0);
  // A mid-line HS pushes the next active pixel to the start of the following line.
  assign w_realign = r_realign | w_hs_err;
  assign w_px      = w_realign ? '0 : r_x;
  assign w_py      = (w_realign && (r_y != Y_MAX)) ? r_y + 1'b1 : r_y;
  assign w_sop     = (w_px == '0) && (w_py == '0);
  assign w_eop     = (w_px == X_MAX) && (w_py == Y_MAX);

  assign w_rd       = stream_valid & stream_ready;
  assign w_take     = r_pv & r_blank &
                      ((r_state == WAIT_ACTIVE) | ((r_state == ACTIVE) & ~w_vs_fall));
  assign w_push     = w_take & (~w_full | w_rd);
  assign w_ovf_set  = w_take & w_full & ~w_rd;
  assign w_ferr_set = ((r_state == ACTIVE) & w_vs_fall) | w_hs_err;
  assign w_wr_word  = '{data: r_rgb, sop: w_sop, eop: w_eop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= WAIT_VS;
      r_x       <= '0;
      r_y       <= '0;
      r_realign <= 1'b0;
    end else begin
      case (r_state)
        WAIT_VS: if (w_vs_fall) r_state <= WAIT_ACTIVE;
        WAIT_ACTIVE, ACTIVE: begin
          if ((r_state == ACTIVE) && w_vs_fall) begin
            r_state   <= WAIT_ACTIVE;
            r_x       <= '0;
            r_y       <= '0;
            r_realign <= 1'b0;
          end else if (w_take) begin
            r_realign <= 1'b0;
            if (!w_push || w_eop) begin
              r_state <= w_push ? WAIT_VS : DROP;
              r_x     <= '0;
              r_y     <= '0;
            end else begin
              r_state <= ACTIVE;
              if (w_px == X_MAX) begin
                r_x <= '0;
                r_y <= w_py + 1'b1;
              end else begin
                r_x <= w_px + 1'b1;
                r_y <= w_py;
              end
            end
          end else if (r_pv) begin
            r_realign <= w_realign;
          end
        end
        DROP: if (w_vs_fall) r_state <= WAIT_ACTIVE;
        default: r_state <= WAIT_VS;
      endcase
    end
  end

  // New error beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= w_ovf_set  ? 1'b1 : (status_clr ? 1'b0 : r_ovf);
      r_ferr <= w_ferr_set ? 1'b1 : (status_clr ? 1'b0 : r_ferr);
    end
  end

  vga_cap_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_take),
    .i_wr_data (w_wr_word),
    .i_rd_en   (stream_ready),
    .o_rd_data (w_rd_word),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign stream_valid         = ~w_empty;
  assign stream_data          = w_rd_word.data;
  assign stream_startofpacket = w_rd_word.sop;
  assign stream_endofpacket   = w_rd_word.eop;
  assign overflow             = r_ovf;
  assign frame_err            = r_ferr;

`ifdef VGA_CAP_FRAME_COUNT_EN
  logic [15:0] r_fc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       r_fc <= '0;
    else if (w_rd && w_rd_word.eop)     r_fc <= r_fc + 1'b1;
  end
  assign frame_count = r_fc;
`endif
endmodule

// File: tb/tb_vga_stream_capture.sv
// tb_vga_stream_capture: directed bench for vga_stream_capture on an 8x4 frame.
module tb_vga_stream_capture;
  localparam int H = 8;
  localparam int V = 4;
  localparam int D = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        vga_HS = 1'b1, vga_VS = 1'b1, vga_BLANK = 1'b0;
  logic [7:0]  vga_R = '0, vga_G = '0, vga_B = '0;
  logic        pix_en = 1'b0, stream_ready = 1'b0, status_clr = 1'b0;
  logic [23:0] stream_data;
  logic        stream_startofpacket, stream_endofpacket, stream_valid;
  logic        overflow, frame_err;
`ifdef VGA_CAP_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  vga_stream_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .vga_HS               (vga_HS),
    .vga_VS               (vga_VS),
    .vga_BLANK            (vga_BLANK),
    .vga_R                (vga_R),
    .vga_G                (vga_G),
    .vga_B                (vga_B),
    .pix_en               (pix_en),
    .stream_data          (stream_data),
    .stream_startofpacket (stream_startofpacket),
    .stream_endofpacket   (stream_endofpacket),
    .stream_valid         (stream_valid),
    .stream_ready         (stream_ready),
    .overflow             (overflow),
    .frame_err            (frame_err),
`ifdef VGA_CAP_FRAME_COUNT_EN
    .status_clr           (status_clr),
    .frame_count          (frame_count)
`else
    .status_clr           (status_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int rmode = 0;  // 0: ready high, 1: ready low, 2: toggle every cycle
  int div = 1;    // pix_en period in clocks
  logic [25:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ready driver
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       stream_ready = 1'b1;
      1:       stream_ready = 1'b0;
      default: stream_ready = ~stream_ready;
    endcase
  end

  // output monitor: transfer scoreboard and stall stability
  initial begin
    logic        prev_stall;
    logic [25:0] prev_w, cur, w;
    prev_stall = 1'b0;
    prev_w     = '0;
    forever begin
      @(negedge clk);
      cur = {stream_data, stream_startofpacket, stream_endofpacket};
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_vld", stream_valid, 1);
          chk("stall_hold", cur, prev_w);
        end
        if (stream_valid && stream_ready) begin
          if (exp_q.size() == 0) chk("extra_xfer", cur, 0);
          else begin
            w = exp_q.pop_front();
            chk("xfer", cur, w);
          end
        end
        prev_stall = stream_valid && !stream_ready;
        prev_w     = cur;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic pix(input logic hs, input logic vs, input logic bl,
                     input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    repeat (div - 1) begin @(posedge clk); #1 pix_en = 1'b0; end
    @(posedge clk); #1;
    pix_en = 1'b1; vga_HS = hs; vga_VS = vs; vga_BLANK = bl;
    vga_R = r; vga_G = g; vga_B = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1 pix_en = 1'b0; end
  endtask

  // VS pulse, then lines of active pixels each followed by an HS pulse.
  // l0: pixels on line 0; cut: stop after this many pixels; nexp: pixels expected out.
  task automatic frame(input logic [7:0] tag, input int l0, input int cut,
                       input int nexp, input bit lat);
    int sent = 0;
    pix(1, 1, 0, 0, 0, 0);
    pix(1, 0, 0, 0, 0, 0);
    pix(1, 0, 0, 0, 0, 0);
    pix(1, 1, 0, 0, 0, 0);
    pix(1, 1, 0, 0, 0, 0);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < ((y == 0) ? l0 : H); x++) begin
        if (sent == cut) return;
        pix(1, 1, 1, tag, 8'(y), 8'(x));
        if (sent < nexp)
          exp_q.push_back({tag, 8'(y), 8'(x), (sent == 0), (x == H-1 && y == V-1)});
        if (lat && sent == 0) begin
          @(posedge clk); #1 pix_en = 1'b0;
          chk("lat_c1_vld", stream_valid, 0);
          @(posedge clk); #1;
          chk("lat_c2_vld", stream_valid, 1);
          chk("lat_c2_data", stream_data, {tag, 16'h0000});
        end
        sent++;
      end
      pix(0, 1, 0, 0, 0, 0);
      pix(1, 1, 0, 0, 0, 0);
    end
    idle(2);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || stream_valid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_in_time", (n < 2000), 1);
    chk("q_left", exp_q.size(), 0);
  endtask

  task automatic clr();
    @(posedge clk); #1 status_clr = 1'b1;
    @(posedge clk); #1 status_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", stream_valid, 0);
    chk("rst_data", stream_data, 0);
    chk("rst_sop", stream_startofpacket, 0);
    chk("rst_eop", stream_endofpacket, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ferr", frame_err, 0);
    reset_n = 1'b1;

    // clean frame with latency probe
    rmode = 0;
    frame(8'h01, H, H*V, H*V, 1'b1);
    drain();
    chk("f1_ovf", overflow, 0);
    chk("f1_ferr", frame_err, 0);

    // overflow: ready low, only the first D pixels survive
    rmode = 1;
    frame(8'h02, H, H*V, D, 1'b0);
    chk("f2_ovf", overflow, 1);
    chk("f2_ferr", frame_err, 0);
    rmode = 0;
    frame(8'h03, H, H*V, H*V, 1'b0);
    drain();
    chk("f3_ovf_sticky", overflow, 1);
    clr();
    chk("f3_ovf_clr", overflow, 0);

    // early VS after 10 pixels
    frame(8'h04, H, 10, 10, 1'b0);
    frame(8'h05, H, H*V, H*V, 1'b0);
    drain();
    chk("f5_ferr", frame_err, 1);
    chk("f5_ovf", overflow, 0);
    clr();
    chk("f5_ferr_clr", frame_err, 0);

    // HS after 3 pixels on line 0: next pixel realigns to (0,1)
    frame(8'h06, 3, 999, 999, 1'b0);
    drain();
    chk("f6_ferr", frame_err, 1);
    clr();

    // ready toggling, slow pixel clock
    rmode = 2; div = 4;
    frame(8'h07, H, H*V, H*V, 1'b0);
    rmode = 0; div = 1;
    drain();
    chk("f7_ovf", overflow, 0);
    chk("f7_ferr", frame_err, 0);

    // mid-frame reset with buffered data and overflow pending
    rmode = 1;
    frame(8'h08, H, 20, 0, 1'b0);
    idle(2);
    chk("pre_rst_vld", stream_valid, 1);
    chk("pre_rst_ovf", overflow, 1);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_vld", stream_valid, 0);
    chk("mid_rst_data", stream_data, 0);
    chk("mid_rst_sop", stream_startofpacket, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_ferr", frame_err, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    rmode = 0;
    for (int i = 0; i < 5; i++) pix(1, 1, 1, 8'hEE, 8'h00, 8'(i));
    idle(4);
    chk("no_vs_no_out", stream_valid, 0);
    frame(8'h09, H, H*V, H*V, 1'b0);
    frame(8'h0A, H, H*V, H*V, 1'b0);
    frame(8'h0B, H, H*V, H*V, 1'b0);
    drain();
    chk("end_ovf", overflow, 0);
    chk("end_ferr", frame_err, 0);
`ifdef VGA_CAP_FRAME_COUNT_EN
    chk("frame_count", frame_count, 3);
`endif
    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
